// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// slave = arbiter side; master = requesters + memory side.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              req0;
   logic              we0;
   logic              lock0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic [3:0]        size0;
   logic              gnt0;
   logic              rvalid0;
   logic [DATA_W-1:0] rdata0;

   logic              req1;
   logic              we1;
   logic              lock1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic [3:0]        size1;
   logic              gnt1;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata1;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_size;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req0, we0, lock0, addr0, wdata0, size0,
      output gnt0, rvalid0, rdata0,
      input  req1, we1, lock1, addr1, wdata1, size1,
      output gnt1, rvalid1, rdata1,
      output mem_addr, mem_we, mem_re, mem_wdata, mem_size,
      input  mem_rdata
   );

   modport master (
      output req0, we0, lock0, addr0, wdata0, size0,
      input  gnt0, rvalid0, rdata0,
      output req1, we1, lock1, addr1, wdata1, size1,
      input  gnt1, rvalid1, rdata1,
      input  mem_addr, mem_we, mem_re, mem_wdata, mem_size,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory with locked sequences and lock timeout.
// Define DMEM_ARB_RR_EN for round-robin on contended idle cycles; otherwise port 0 has priority.
//
// state | meaning
// IDLE  | no owner; grant by request / arbitration policy
// OWN0  | port 0 holds a lock; only port 0 may be granted
// OWN1  | port 1 holds a lock; only port 1 may be granted
module dmem_arbiter #(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int LOCK_MAX = 8
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic              force_q, force_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic gnt0_c, gnt1_c;
   logic win1, own1, own_req, own_lock;
   logic policy_pick, contend_pick;

`ifdef DMEM_ARB_RR_EN
   assign policy_pick = rr_ptr_q;
`else
   assign policy_pick = 1'b0;
`endif

   // After a forced release the displaced port wins once, whatever the policy.
   assign contend_pick = force_q ? rr_ptr_q : policy_pick;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      lock_cnt_d = lock_cnt_q;
      force_d    = 1'b0;
      gnt0_c     = 1'b0;
      gnt1_c     = 1'b0;
      win1       = 1'b0;
      own1       = (state_q == ST_OWN1);
      own_req    = own1 ? bus.req1  : bus.req0;
      own_lock   = own1 ? bus.lock1 : bus.lock0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req0 || bus.req1) begin
               win1     = bus.req1 && (!bus.req0 || contend_pick);
               gnt0_c   = ~win1;
               gnt1_c   = win1;
               rr_ptr_d = ~win1;
               if (win1 ? bus.lock1 : bus.lock0) begin
                  if (LOCK_MAX <= 1) begin
                     force_d = 1'b1;
                  end else begin
                     state_d    = win1 ? ST_OWN1 : ST_OWN0;
                     lock_cnt_d = CNT_ONE;
                  end
               end
            end
         end
         ST_OWN0, ST_OWN1: begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
            rr_ptr_d   = ~own1;
            if (own_req) begin
               gnt0_c = ~own1;
               gnt1_c = own1;
               if (own_lock) begin
                  if (lock_cnt_q + CNT_ONE >= CNT_MAX) begin
                     force_d = 1'b1;
                  end else begin
                     state_d    = state_q;
                     lock_cnt_d = lock_cnt_q + CNT_ONE;
                  end
               end
            end
         end
         default: begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
         end
      endcase
   end

   // Outputs are forced quiet while reset is held; flop inputs use the ungated grant.
   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_size  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      if (gnt1_c) begin
         bus.mem_addr  = bus.addr1;
         bus.mem_wdata = bus.wdata1;
         bus.mem_size  = bus.size1;
         bus.mem_we    = reset & bus.we1;
         bus.mem_re    = reset & ~bus.we1;
      end else if (gnt0_c) begin
         bus.mem_addr  = bus.addr0;
         bus.mem_wdata = bus.wdata0;
         bus.mem_size  = bus.size0;
         bus.mem_we    = reset & bus.we0;
         bus.mem_re    = reset & ~bus.we0;
      end
   end

   assign bus.gnt0 = gnt0_c & reset;
   assign bus.gnt1 = gnt1_c & reset;

   always_comb begin
      rvalid0_d = gnt0_c & ~bus.we0;
      rvalid1_d = gnt1_c & ~bus.we1;
      rdata0_d  = rvalid0_d ? bus.mem_rdata : rdata0_q;
      rdata1_d  = rvalid1_d ? bus.mem_rdata : rdata1_q;
   end

   assign bus.rvalid0 = rvalid0_q;
   assign bus.rvalid1 = rvalid1_q;
   assign bus.rdata0  = rdata0_q;
   assign bus.rdata1  = rdata1_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= 1'b0;
         lock_cnt_q <= '0;
         force_q    <= 1'b0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_cnt_q <= lock_cnt_d;
         force_q    <= force_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model of ownership, lock counting and arbitration.
module tb_dmem_arbiter;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int LM = 8;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [DW-1:0] mem [256];
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
   assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

   logic          r_req [2];
   logic          r_we  [2];
   logic          r_lock[2];
   logic [AW-1:0] r_addr[2];
   logic [DW-1:0] r_wdata[2];
   logic [3:0]    r_size[2];

   int owner, held, favour;
   bit forced;
   logic          exp_rv[2];
   logic [DW-1:0] exp_rd[2];

   int checks = 0;
   int errors = 0;
   int g_obs;
   int w;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic apply();
      bus.req0 = r_req[0]; bus.we0 = r_we[0]; bus.lock0 = r_lock[0];
      bus.addr0 = r_addr[0]; bus.wdata0 = r_wdata[0]; bus.size0 = r_size[0];
      bus.req1 = r_req[1]; bus.we1 = r_we[1]; bus.lock1 = r_lock[1];
      bus.addr1 = r_addr[1]; bus.wdata1 = r_wdata[1]; bus.size1 = r_size[1];
   endtask

   task automatic set_port(input int p, input logic rq, input logic wr, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      r_req[p] = rq; r_we[p] = wr; r_lock[p] = lk;
      r_addr[p] = a; r_wdata[p] = d; r_size[p] = 4'd8;
   endtask

   task automatic new_req(input int p);
      r_req[p]   = ($urandom_range(99) < 70);
      r_we[p]    = 1'($urandom_range(1));
      r_lock[p]  = ($urandom_range(99) < 45);
      r_addr[p]  = 64'($urandom_range(31) * 8);
      r_wdata[p] = {$urandom, $urandom};
      r_size[p]  = 4'(1 << $urandom_range(3));
   endtask

   task automatic model_reset();
      owner = -1; held = 0; favour = 0; forced = 0;
      for (int p = 0; p < 2; p++) begin
         exp_rv[p] = 1'b0;
         exp_rd[p] = '0;
      end
   endtask

   function automatic int winner();
      if (owner >= 0) return r_req[owner] ? owner : -1;
      if (r_req[0] && r_req[1]) begin
`ifdef DMEM_ARB_RR_EN
         return favour;
`else
         return forced ? favour : 0;
`endif
      end
      if (r_req[0]) return 0;
      if (r_req[1]) return 1;
      return -1;
   endfunction

   task automatic model_update(input int win);
      bit f;
      f = 0;
      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
      if (win >= 0 && !r_we[win]) begin
         exp_rv[win] = 1'b1;
         exp_rd[win] = mem[r_addr[win][7:0]];
      end
      if (owner >= 0) begin
         if (win < 0 || !r_lock[win]) begin
            favour = 1 - owner; owner = -1; held = 0;
         end else begin
            held++;
            if (held == LM) begin
               favour = 1 - owner; owner = -1; held = 0; f = 1;
            end
         end
      end else if (win >= 0) begin
         favour = 1 - win;
         if (r_lock[win]) begin
            if (LM <= 1) f = 1;
            else begin owner = win; held = 1; end
         end
      end
      forced = f;
   endtask

   task automatic step(output int win);
      logic          e_we, e_re;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      logic [3:0]    e_sz;
      @(negedge clk);
      win = winner();
      e_we = 0; e_re = 0; e_addr = '0; e_wd = '0; e_sz = '0;
      if (win >= 0) begin
         e_we = r_we[win]; e_re = !r_we[win];
         e_addr = r_addr[win]; e_wd = r_wdata[win]; e_sz = r_size[win];
      end
      g_obs = bus.gnt1 ? 1 : (bus.gnt0 ? 0 : -1);
      check("gnt0", 64'(bus.gnt0), 64'(win == 0));
      check("gnt1", 64'(bus.gnt1), 64'(win == 1));
      check("mem_we", 64'(bus.mem_we), 64'(e_we));
      check("mem_re", 64'(bus.mem_re), 64'(e_re));
      check("mem_addr", bus.mem_addr, e_addr);
      check("mem_wdata", bus.mem_wdata, e_wd);
      check("mem_size", 64'(bus.mem_size), 64'(e_sz));
      check("rvalid0", 64'(bus.rvalid0), 64'(exp_rv[0]));
      check("rvalid1", 64'(bus.rvalid1), 64'(exp_rv[1]));
      check("rdata0", bus.rdata0, exp_rd[0]);
      check("rdata1", bus.rdata1, exp_rd[1]);
      @(posedge clk);
      model_update(win);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      set_port(0, 0, 0, 0, '0, '0);
      set_port(1, 0, 0, 0, '0, '0);
      apply();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
      do_reset();
      check("rst_rvalid0", 64'(bus.rvalid0), 64'd0);
      check("rst_rdata1", bus.rdata1, 64'd0);

      // single read
      mem[8'h40] = 64'hDEAD;
      set_port(0, 1, 0, 0, 64'h40, '0); apply();
      step(w);
      check("t1_grant", 64'(g_obs), 64'(0));
      set_port(0, 0, 0, 0, '0, '0); apply();
      check("t1_rvalid0", 64'(bus.rvalid0), 64'd1);
      check("t1_rdata0", bus.rdata0, 64'hDEAD);
      check("t1_rvalid1", 64'(bus.rvalid1), 64'd0);
      step(w);

      // contention, both reads
      do_reset();
      set_port(0, 1, 0, 0, 64'h08, '0);
      set_port(1, 1, 0, 0, 64'h20, '0); apply();
      for (int i = 0; i < 4; i++) begin
         step(w);
`ifdef DMEM_ARB_RR_EN
         check("t2_grant", 64'(g_obs), 64'(i % 2));
`else
         check("t2_grant", 64'(g_obs), 64'(0));
`endif
         r_addr[0] = r_addr[0] + 64'd8;
         r_addr[1] = r_addr[1] + 64'd8;
         apply();
      end

      // locked write pair while port 1 waits
      do_reset();
      set_port(0, 1, 1, 1, 64'h10, 64'h1111_AAAA);
      set_port(1, 1, 0, 0, 64'h80, '0); apply();
      step(w); check("t3_first", 64'(g_obs), 64'(0));
      set_port(0, 1, 1, 0, 64'h18, 64'h2222_BBBB); apply();
      step(w); check("t3_second", 64'(g_obs), 64'(0));
      set_port(0, 0, 0, 0, '0, '0); apply();
      step(w); check("t3_third", 64'(g_obs), 64'(1));
      check("t3_mem10", mem[8'h10], 64'h1111_AAAA);
      check("t3_mem18", mem[8'h18], 64'h2222_BBBB);

      // lock timeout
      do_reset();
      set_port(0, 1, 1, 1, 64'h30, 64'h5);
      set_port(1, 1, 0, 0, 64'h88, '0); apply();
      for (int i = 0; i < LM + 1; i++) begin
         step(w);
         check("t4_grant", 64'(g_obs), 64'((i < LM) ? 0 : 1));
      end

      // lock abandon
      do_reset();
      set_port(1, 1, 0, 1, 64'h48, '0); apply();
      step(w); check("t5_own", 64'(g_obs), 64'(1));
      set_port(1, 0, 0, 0, '0, '0);
      set_port(0, 1, 0, 0, 64'h50, '0); apply();
      step(w); check("t5_gap", 64'(g_obs), 64'(-1));
      step(w); check("t5_after", 64'(g_obs), 64'(0));

      // async reset mid-lock with read data pending
      do_reset();
      set_port(0, 1, 0, 1, 64'h60, '0);
      set_port(1, 1, 1, 0, 64'h68, 64'h77); apply();
      step(w);
      check("t6_rv_pre", 64'(bus.rvalid0), 64'd1);
      r_we[0] = 1'b1; apply();
      #2 reset = 1'b0;
      #1;
      model_reset();
      check("t6_gnt0", 64'(bus.gnt0), 64'd0);
      check("t6_gnt1", 64'(bus.gnt1), 64'd0);
      check("t6_rvalid0", 64'(bus.rvalid0), 64'd0);
      check("t6_rvalid1", 64'(bus.rvalid1), 64'd0);
      check("t6_mem_we", 64'(bus.mem_we), 64'd0);
      set_port(0, 0, 0, 0, '0, '0);
      set_port(1, 0, 0, 0, '0, '0); apply();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      set_port(0, 1, 0, 0, 64'h70, '0);
      set_port(1, 1, 0, 0, 64'h78, '0); apply();
      step(w); check("t6_first", 64'(g_obs), 64'(0));

      // random traffic, fields held until granted
      do_reset();
      new_req(0); new_req(1); apply();
      for (int i = 0; i < 600; i++) begin
         step(w);
         for (int p = 0; p < 2; p++)
            if (!r_req[p] || w == p) new_req(p);
         apply();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
